// File: rtl/at_cmd_responder.sv
// at_cmd_responder: answers "AT...\r\n" commands from a UART RX FIFO with "OK\r\n" or "ERROR\r\n".
// Optional inter-byte receive timeout is enabled by defining AT_RESP_TIMEOUT_EN.
module at_cmd_responder #(
  parameter int MAX_CMD_LEN    = 16,
  parameter int TIMEOUT_CYCLES = 2_083_340
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_rd_en,
  input  logic       tx_full,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       cmd_done,
  output logic [7:0] ok_cnt,
  output logic [7:0] err_cnt,
  output logic       rx_timeout
);
  localparam int LW = $clog2(MAX_CMD_LEN + 2);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_CMD_LEN);
  localparam logic [2:0] IDLE = 3'd0, RECV = 3'd1, CHECK = 3'd2, SEND_OK = 3'd3, SEND_ERR = 3'd4;
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A;
  // Both responses are left-aligned in a 7-byte window; byte i sits at bits [55-8i -: 8].
  localparam logic [55:0] OK_MSG = {"OK", CR, LF, 24'h0};
  localparam logic [55:0] ERR_MSG = {"ERROR", CR, LF};

  logic [2:0] state_q, state_d, idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic ovf_q, ovf_d, b0_q, b0_d, b1_q, b1_d, pcr_q, pcr_d;
  logic [7:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic sending, done, consume, p, cnt_en, tmo_hit;
  logic [7:0] c;

  assign rx_rd_en = consume;
  assign cmd_done = done;
  assign ok_cnt = ok_cnt_q;
  assign err_cnt = err_cnt_q;
  assign rx_timeout = tmo_hit;

  // Receive parsing, response sequencing and counter updates.
  always_comb begin
    sending = state_q == SEND_OK || state_q == SEND_ERR;
    done = sending && idx_q == (state_q == SEND_OK ? 3'd4 : 3'd7);
    tx_valid = sending && !done && !tx_full;
    tx_byte = sending && !done ? 8'((state_q == SEND_OK ? OK_MSG : ERR_MSG) >> {3'd6 - idx_q, 3'b000}) : 8'h00;
    consume = rx_valid && !rst && (state_q == IDLE || state_q == RECV);
    state_d = state_q;
    idx_d = sending ? idx_q + {2'b00, tx_valid} : 3'd0;
    len_d = state_q == IDLE ? '0 : len_q;
    ovf_d = state_q == IDLE ? 1'b0 : ovf_q;
    b0_d = state_q == IDLE ? 1'b0 : b0_q;
    b1_d = state_q == IDLE ? 1'b0 : b1_q;
    pcr_d = state_q == IDLE ? 1'b0 : pcr_q;
    p = pcr_d;
    c = 8'h00;
    cnt_en = 1'b0;
    if (consume) begin
      state_d = RECV;
      if (p && rx_byte == LF) begin
        state_d = CHECK;
        pcr_d = 1'b0;
      end else begin
        // A held-back CR that turned out not to start a terminator counts first, then the new byte.
        for (int i = 0; i < 2; i++) begin
          c = i == 0 ? CR : rx_byte;
          cnt_en = i == 0 ? p : rx_byte != CR;
          if (cnt_en) begin
            if (len_d == MAX_L) ovf_d = 1'b1;
            else begin
              if (len_d == LW'(0)) b0_d = c == "A";
              if (len_d == LW'(1)) b1_d = c == "T";
              len_d = len_d + LW'(1);
            end
          end
        end
        pcr_d = rx_byte == CR;
      end
    end else if (tmo_hit) state_d = IDLE;
    if (state_q == CHECK) state_d = len_q >= LW'(2) && b0_q && b1_q && !ovf_q ? SEND_OK : SEND_ERR;
    if (done) state_d = IDLE;
    ok_cnt_d = done && state_q == SEND_OK && ok_cnt_q != 8'hFF ? ok_cnt_q + 8'd1 : ok_cnt_q;
    err_cnt_d = done && state_q == SEND_ERR && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
      b0_q <= 1'b0;
      b1_q <= 1'b0;
      pcr_q <= 1'b0;
      ok_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      pcr_q <= pcr_d;
      ok_cnt_q <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef AT_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Idle-cycle counter in RECV; restarts on every consumed byte.
  always_comb begin
    tmo_hit = state_q == RECV && !consume && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    tmo_d = state_q != RECV || consume || tmo_hit ? '0 : tmo_q + TW'(1);
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif
endmodule
